endstop_capture: RTL and testbench
==================================

Name: endstop_capture

Overview:
- Consumer stage directly downstream of the per-input debouncer. Takes the debouncer's locked edge report (sig_out, sig_changed, pos_out, cycles) and decides whether the edge is a valid trigger.
- On a valid trigger it latches the captured position and bounce count, raises a motion stop request, and waits for host acknowledge.
- In every case it issues the debouncer's unlock pulse, so the debouncer can report the next edge.
- One instance per endstop/probe input, between the debouncer and the motion controller/host register file.

Parameters:
- POS_W, 64, width of position bus (matches debouncer pos_out).
- MISS_W, 16, width of missed-edge counter.
- REL_TMO, 15, max cycles to wait for sig_changed to drop after unlock before flagging error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; 1 = armed for capture
- polarity  in  1  sig_out value that constitutes a trigger
- ack  in  1  one-cycle host acknowledge of a trigger
- sig_out  in  1  debounced level from debouncer
- sig_changed  in  1  debouncer "edge locked" flag
- pos_in  in  POS_W  debouncer captured position
- cycles_in  in  8  debouncer edge counter
- unlock  out  1  one-cycle unlock pulse to debouncer
- stop_req  out  1  level stop request to motion controller
- triggered  out  1  status: capture valid, awaiting ack
- cap_pos  out  POS_W  latched trigger position
- cap_cycles  out  8  cycles_in latched at trigger
- missed  out  MISS_W  count of edges released without capture, saturating
- rel_err  out  1  sticky: debouncer failed to release within REL_TMO

Behaviour:
- All outputs are registered. Reset values: unlock=0, stop_req=0, triggered=0, cap_pos=0, cap_cycles=0, missed=0, rel_err=0, state=IDLE, release timer=0.
- Reset mid-operation aborts any state at the next edge. stop_req drops with no unlock pulse.
- States:
  - IDLE (enable=0)
  - ARMED
  - TRIGGERED
  - REL_IDLE (releasing, return to IDLE/ARMED per enable)
  - REL_HOLD (releasing after ack)
- IDLE:
  - sig_changed=1: missed+1, unlock=1 next cycle, go REL_IDLE.
  - else enable=1: go ARMED.
  - sig_changed has priority over enable in the same cycle.
- ARMED:
  - sig_changed=1 and sig_out==polarity: next edge sets cap_pos<=pos_in, cap_cycles<=cycles_in, stop_req<=1, triggered<=1; go TRIGGERED.
  - sig_changed=1 and sig_out!=polarity: missed+1, unlock pulse, go REL_IDLE.
  - else enable=0: go IDLE.
  - The trigger check takes priority over enable=0 in the same cycle.
- TRIGGERED:
  - Hold cap_pos, cap_cycles, stop_req and triggered regardless of enable or further inputs.
  - ack=1: unlock pulse, stop_req<=0, triggered<=0, go REL_HOLD.
  - ack outside TRIGGERED is ignored.
- Release states (REL_IDLE, REL_HOLD):
  - unlock is high exactly one cycle, on the first cycle of the state.
  - The debouncer clears sig_changed one cycle after it samples unlock, so sig_changed is still 1 on that first cycle and must not be re-evaluated.
  - The release timer counts from 0 on state entry.
  - Exit when sig_changed=0 and timer>=1: go ARMED if enable=1, else IDLE.
  - Timer reaching REL_TMO with sig_changed still 1: rel_err<=1 (sticky until reset), then exit as above.
- cap_pos and cap_cycles change only on a valid trigger and otherwise hold.
- missed saturates at all-ones, with no wrap.
- unlock is never high for two consecutive cycles. unlock is never asserted in IDLE, ARMED or TRIGGERED except on the transition edge into a release state.
- Latency: sig_changed rising (cycle t) produces stop_req=1 and the capture registers valid at cycle t+1.

Test Plan:
- enable=1, polarity=1; debouncer edge with sig_out=1, pos_in=0x1234, cycles_in=3 -> at t+1 stop_req=1, triggered=1, cap_pos=0x1234, cap_cycles=3; unlock stays 0 until ack.
- From TRIGGERED, pulse ack -> next cycle unlock=1 for exactly 1 cycle, stop_req=0; debouncer drops sig_changed -> back to ARMED; second edge captures new pos.
- enable=1, polarity=1, edge with sig_out=0 -> no stop_req, missed 0->1, single unlock pulse, returns to ARMED; cap_pos unchanged.
- enable=0, three edges -> missed=3, three single unlock pulses, stop_req never asserted; preload missed=0xFFFF via repeated edges -> stays 0xFFFF.
- Hold sig_changed=1 after unlock for 20 cycles (REL_TMO=15) -> rel_err=1 at timer=15; state exits; rel_err remains 1 until reset.
- In TRIGGERED assert reset for 1 cycle -> next cycle stop_req=0, triggered=0, cap_pos=0, missed=0, no unlock pulse; trigger and enable=0 in same cycle -> capture still occurs.

Source files
------------

// File: rtl/endstop_capture_if.sv
// Endstop capture bus: debouncer edge report, host control and capture status.
interface endstop_capture_if #(
    parameter int POS_W  = 64,
    parameter int MISS_W = 16
);
    logic              enable;
    logic              polarity;
    logic              ack;
    logic              sig_out;
    logic              sig_changed;
    logic [POS_W-1:0]  pos_in;
    logic [7:0]        cycles_in;
    logic              unlock;
    logic              stop_req;
    logic              triggered;
    logic [POS_W-1:0]  cap_pos;
    logic [7:0]        cap_cycles;
    logic [MISS_W-1:0] missed;
    logic              rel_err;

    // Capture block side
    modport slave (
        input  enable, polarity, ack, sig_out, sig_changed, pos_in, cycles_in,
        output unlock, stop_req, triggered, cap_pos, cap_cycles, missed, rel_err
    );

    // Debouncer/host side
    modport master (
        output enable, polarity, ack, sig_out, sig_changed, pos_in, cycles_in,
        input  unlock, stop_req, triggered, cap_pos, cap_cycles, missed, rel_err
    );
endinterface

// File: rtl/endstop_capture.sv
// Endstop capture: qualifies locked debouncer edges as triggers, latches the
// trigger position, raises a stop request until host ack, and always hands the
// debouncer a single unlock pulse so it can report the next edge.
module endstop_capture #(
    parameter int POS_W   = 64,
    parameter int MISS_W  = 16,
    parameter int REL_TMO = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    endstop_capture_if.slave     bus
);
    localparam int TMR_W = $clog2(REL_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_TRIG,
        S_REL_IDLE,
        S_REL_HOLD
    } state_t;

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic              r_unlock;
    logic              r_stop_req;
    logic              r_triggered;
    logic [POS_W-1:0]  r_cap_pos;
    logic [7:0]        r_cap_cycles;
    logic [MISS_W-1:0] r_missed;
    logic              r_rel_err;

    logic [MISS_W-1:0] w_missed_inc;
    logic              w_hit;

    // Saturating increment of the missed-edge count and trigger qualification
    always_comb begin
        w_missed_inc = (r_missed == '1) ? r_missed : r_missed + MISS_W'(1);
        w_hit        = bus.sig_changed && (bus.sig_out == bus.polarity);
    end

    // Capture state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_unlock     <= 1'b0;
            r_stop_req   <= 1'b0;
            r_triggered  <= 1'b0;
            r_cap_pos    <= '0;
            r_cap_cycles <= '0;
            r_missed     <= '0;
            r_rel_err    <= 1'b0;
        end else begin
            r_unlock <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.sig_changed) begin
                        r_missed <= w_missed_inc;
                        r_unlock <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= S_REL_IDLE;
                    end else if (bus.enable) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_hit) begin
                        r_cap_pos    <= bus.pos_in;
                        r_cap_cycles <= bus.cycles_in;
                        r_stop_req   <= 1'b1;
                        r_triggered  <= 1'b1;
                        r_state      <= S_TRIG;
                    end else if (bus.sig_changed) begin
                        r_missed <= w_missed_inc;
                        r_unlock <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= S_REL_IDLE;
                    end else if (!bus.enable) begin
                        r_state <= S_IDLE;
                    end
                end
                S_TRIG: begin
                    if (bus.ack) begin
                        r_unlock    <= 1'b1;
                        r_stop_req  <= 1'b0;
                        r_triggered <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= S_REL_HOLD;
                    end
                end
                S_REL_IDLE, S_REL_HOLD: begin
                    // sig_changed is still high on the first cycle (timer=0)
                    // because the debouncer only just sampled unlock.
                    if (!bus.sig_changed && (r_timer != '0)) begin
                        r_timer <= '0;
                        r_state <= bus.enable ? S_ARMED : S_IDLE;
                    end else if (r_timer == TMR_W'(REL_TMO)) begin
                        r_rel_err <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= bus.enable ? S_ARMED : S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.unlock     = r_unlock;
    assign bus.stop_req   = r_stop_req;
    assign bus.triggered  = r_triggered;
    assign bus.cap_pos    = r_cap_pos;
    assign bus.cap_cycles = r_cap_cycles;
    assign bus.missed     = r_missed;
    assign bus.rel_err    = r_rel_err;
endmodule

// File: tb/tb_endstop_capture.sv
// Directed bench for endstop_capture: a vector table walks the main state
// paths, followed by hand sequences for reset abort, saturation and timeout.
module tb_endstop_capture;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    endstop_capture_if #(.POS_W(64), .MISS_W(4)) bus ();

    endstop_capture #(.POS_W(64), .MISS_W(4), .REL_TMO(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, pol, ack, so, sc;
        logic [63:0] pos;
        logic [7:0]  cyc;
        logic        unl, stop, trig;
        logic [63:0] cpos;
        logic [7:0]  ccyc;
        logic [3:0]  miss;
        logic        err;
    } vec_t;

    vec_t tbl [0:22];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic pol, input logic ack,
                         input logic so, input logic sc,
                         input logic [63:0] pos, input logic [7:0] cyc);
        bus.enable      = en;
        bus.polarity    = pol;
        bus.ack         = ack;
        bus.sig_out     = so;
        bus.sig_changed = sc;
        bus.pos_in      = pos;
        bus.cycles_in   = cyc;
    endtask

    task automatic check_all(input string nm, input logic unl, input logic stop,
                             input logic trig, input logic [63:0] cpos,
                             input logic [7:0] ccyc, input logic [3:0] miss,
                             input logic err);
        check({nm, ".unlock"},     64'(bus.unlock),     64'(unl));
        check({nm, ".stop_req"},   64'(bus.stop_req),   64'(stop));
        check({nm, ".triggered"},  64'(bus.triggered),  64'(trig));
        check({nm, ".cap_pos"},    bus.cap_pos,         cpos);
        check({nm, ".cap_cycles"}, 64'(bus.cap_cycles), 64'(ccyc));
        check({nm, ".missed"},     64'(bus.missed),     64'(miss));
        check({nm, ".rel_err"},    64'(bus.rel_err),    64'(err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            en    pol   ack   so    sc    pos_in        cyc     unl   stop  trig  cap_pos       ccyc    miss   err
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,      8'd0,  1'b0, 1'b0, 1'b0, 64'h0,      8'd0, 4'd0, 1'b0}; // -> ARMED
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1234,   8'd3,  1'b0, 1'b1, 1'b1, 64'h1234,   8'd3, 4'd0, 1'b0}; // trigger
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h9999,   8'd8,  1'b0, 1'b1, 1'b1, 64'h1234,   8'd3, 4'd0, 1'b0}; // hold
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h5555,   8'd9,  1'b0, 1'b1, 1'b1, 64'h1234,   8'd3, 4'd0, 1'b0}; // enable ignored
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h5555,   8'd9,  1'b1, 1'b0, 1'b0, 64'h1234,   8'd3, 4'd0, 1'b0}; // ack -> REL_HOLD
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h5555,   8'd9,  1'b0, 1'b0, 1'b0, 64'h1234,   8'd3, 4'd0, 1'b0}; // timer 0
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h5555,   8'd9,  1'b0, 1'b0, 1'b0, 64'h1234,   8'd3, 4'd0, 1'b0}; // -> ARMED
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'hABCD,   8'd7,  1'b0, 1'b1, 1'b1, 64'hABCD,   8'd7, 4'd0, 1'b0}; // second capture
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hABCD,   8'd7,  1'b1, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd0, 1'b0}; // ack
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'hABCD,   8'd7,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hABCD,   8'd7,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd0, 1'b0}; // -> ARMED
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h7777,   8'd9,  1'b1, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd1, 1'b0}; // wrong polarity
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h7777,   8'd9,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h7777,   8'd9,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd1, 1'b0}; // -> ARMED
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,      8'd0,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd1, 1'b0}; // -> IDLE
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,      8'd0,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd1, 1'b0}; // stray ack
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h4444,   8'd4,  1'b1, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd2, 1'b0}; // IDLE edge
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h4444,   8'd4,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd2, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h4444,   8'd4,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd2, 1'b0}; // -> IDLE
        tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h3333,   8'd2,  1'b1, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd3, 1'b0}; // edge beats enable
        tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h3333,   8'd2,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd3, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h3333,   8'd2,  1'b0, 1'b0, 1'b0, 64'hABCD,   8'd7, 4'd3, 1'b0}; // -> ARMED
        tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h2222,   8'd5,  1'b0, 1'b1, 1'b1, 64'h2222,   8'd5, 4'd3, 1'b0}; // trigger beats enable=0

        // Reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'd0);
        step();
        step();
        check_all("reset", 1'b0, 1'b0, 1'b0, 64'h0, 8'd0, 4'd0, 1'b0);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].en, tbl[i].pol, tbl[i].ack, tbl[i].so, tbl[i].sc, tbl[i].pos, tbl[i].cyc);
            step();
            check_all($sformatf("row%0d", i), tbl[i].unl, tbl[i].stop, tbl[i].trig,
                      tbl[i].cpos, tbl[i].ccyc, tbl[i].miss, tbl[i].err);
        end

        // Reset while TRIGGERED: everything clears, no unlock pulse
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 8'd0);
        step();
        check_all("rst_trig", 1'b0, 1'b0, 1'b0, 64'h0, 8'd0, 4'd0, 1'b0);
        reset = 1'b0;
        step();
        check("rst_trig.post_unlock", 64'(bus.unlock), 64'h0);

        // Missed-edge saturation with enable=0
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0, 8'd0);
            step();
            check($sformatf("sat%0d.unlock", i), 64'(bus.unlock), 64'h1);
            check($sformatf("sat%0d.missed", i), 64'(bus.missed), (i + 1 > 15) ? 64'd15 : 64'(i + 1));
            step();
            check($sformatf("sat%0d.unlock2", i), 64'(bus.unlock), 64'h0);
            bus.sig_changed = 1'b0;
            step();
            check($sformatf("sat%0d.stop", i), 64'(bus.stop_req), 64'h0);
        end

        // Release timeout: sig_changed stuck high for 20 cycles after unlock
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 8'd0);
        step();
        bus.sig_changed = 1'b1;
        step();
        check("tmo0.unlock", 64'(bus.unlock), 64'h1);
        check("tmo0.rel_err", 64'(bus.rel_err), 64'h0);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("tmo%0d.unlock", k), 64'(bus.unlock), (k == 17) ? 64'h1 : 64'h0);
            check($sformatf("tmo%0d.rel_err", k), 64'(bus.rel_err), (k >= 16) ? 64'h1 : 64'h0);
        end
        bus.sig_changed = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("tmo.sticky", 64'(bus.rel_err), 64'h1);
        check("tmo.missed_sat", 64'(bus.missed), 64'd15);
        reset = 1'b1;
        step();
        check("tmo.reset", 64'(bus.rel_err), 64'h0);
        reset = 1'b0;

        // polarity=0 trigger with full-width position, then ack pulse shape
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        step();
        check_all("pol0", 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 4'd0, 1'b0);
        bus.ack = 1'b1;
        step();
        check("pol0.ack_unlock", 64'(bus.unlock), 64'h1);
        check("pol0.ack_stop", 64'(bus.stop_req), 64'h0);
        bus.ack = 1'b0;
        step();
        check("pol0.unlock_once", 64'(bus.unlock), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
